// File: rtl/cmd_handler.sv
// cmd_handler: decodes host function codes into capture-core pulses, buffer config and result registers.
// Define CMD_HANDLER_ACK_TIMEOUT_EN to abandon ACK_WAIT after ACK_TIMEOUT_CLKS cycles without a host ACK.
module cmd_handler #(
   parameter int SAMPLE_W         = 32,
   parameter int ACK_TIMEOUT_CLKS = 65535
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [7:0]          command,
   input  logic                commandStrobe,
   input  logic [7:0]          regIn0,
   input  logic [7:0]          regIn1,
   input  logic [7:0]          regIn2,
   input  logic [7:0]          regIn3,
   input  logic [7:0]          regIn4,
   input  logic [7:0]          regIn5,
   input  logic [7:0]          regIn6,
   input  logic [7:0]          regIn7,
   output logic [7:0]          regOut0,
   output logic [7:0]          regOut1,
   output logic [7:0]          regOut2,
   output logic [7:0]          regOut3,
   output logic [7:0]          regOut4,
   output logic [7:0]          regOut5,
   output logic [7:0]          regOut6,
   output logic [7:0]          regOut7,
   output logic [7:0]          status,
   input  logic                capArmed,
   input  logic                capTriggered,
   input  logic                capDone,
   output logic                startPulse,
   output logic                abortPulse,
   output logic                softResetPulse,
   output logic [31:0]         cfgTotal,
   output logic [31:0]         cfgPreTrig,
   output logic                cfgValid,
   output logic                rdReq,
   input  logic [SAMPLE_W-1:0] rdData,
   input  logic                rdValid,
   input  logic [31:0]         traceSize,
   input  logic [31:0]         trigSample
);
   localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RD_WAIT = 2'd2, ACK_WAIT = 2'd3;
   localparam logic [7:0] C_NOP = 8'h00, C_START = 8'h01, C_ABORT = 8'h02, C_CFG = 8'h04, C_RDDATA = 8'h05;
   localparam logic [7:0] C_SIZE = 8'h06, C_TRIG = 8'h07, C_ACK = 8'h08, C_RESET = 8'h09, C_TRIG_ALT = 8'h10;

   if (ACK_TIMEOUT_CLKS < 1) begin : g_bad_timeout
      $error("cmd_handler: ACK_TIMEOUT_CLKS must be at least 1");
   end

   logic [1:0]  state;
   logic [7:0]  cmd_q;
   logic [63:0] arg_q;
   logic [63:0] out_q;
   logic        error;
   logic        exec;
   logic        cfg_ok;
   logic        legal;
   logic        exec_err;
   logic        do_read;
   logic        ack_cmd;
   logic        timeout;
   logic [31:0] new_total;
   logic [31:0] new_pre;
   logic [31:0] rd_word;

   assign new_total = arg_q[31:0];
   assign new_pre   = arg_q[63:32];
   assign rd_word   = 32'(rdData);
   assign exec      = state == EXEC;
   assign cfg_ok    = new_pre != 32'd0 && new_pre < new_total;
   assign legal     = cmd_q inside {C_START, C_ABORT, C_CFG, C_RDDATA, C_SIZE, C_TRIG, C_TRIG_ALT, C_RESET};
   assign exec_err  = !legal || (cmd_q == C_START && capArmed) || (cmd_q == C_CFG && !cfg_ok) ||
                      (cmd_q == C_RDDATA && !capDone);
   assign do_read   = exec && cmd_q == C_RDDATA && capDone;
   assign ack_cmd   = commandStrobe && command == C_ACK;
   assign rdReq     = do_read || state == RD_WAIT;
   assign {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0} = out_q;
   assign status    = {2'b00, state != IDLE, error, state == ACK_WAIT, capDone, capTriggered, capArmed};

`ifdef CMD_HANDLER_ACK_TIMEOUT_EN
   logic [31:0] ack_cnt;
   assign timeout = state == ACK_WAIT && ack_cnt == 32'(ACK_TIMEOUT_CLKS - 1);
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) ack_cnt <= '0;
      else ack_cnt <= state == ACK_WAIT ? ack_cnt + 32'd1 : '0;
`else
   assign timeout = 1'b0;
`endif

   // Actions decided in EXEC land on the following edge, so pulses are exactly one cycle wide.
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         state          <= IDLE;
         cmd_q          <= '0;
         arg_q          <= '0;
         out_q          <= '0;
         error          <= 1'b0;
         cfgTotal       <= '0;
         cfgPreTrig     <= '0;
         cfgValid       <= 1'b0;
         startPulse     <= 1'b0;
         abortPulse     <= 1'b0;
         softResetPulse <= 1'b0;
      end else begin
         startPulse     <= exec && cmd_q == C_START && !capArmed;
         abortPulse     <= exec && cmd_q == C_ABORT;
         softResetPulse <= exec && cmd_q == C_RESET;
         cfgValid       <= exec && cmd_q == C_CFG && cfg_ok;
         if (exec && cmd_q == C_CFG && cfg_ok) begin
            cfgTotal   <= new_total;
            cfgPreTrig <= new_pre;
         end
         if (exec && cmd_q == C_SIZE) out_q <= {32'd0, traceSize};
         if (exec && (cmd_q == C_TRIG || cmd_q == C_TRIG_ALT)) out_q <= {32'd0, trigSample};
         if (state == RD_WAIT && rdValid) out_q <= {32'd0, rd_word};
         if (exec && exec_err) error <= 1'b1;
         case (state)
            IDLE: if (commandStrobe && command != C_NOP && command != C_ACK) begin
               state <= EXEC;
               cmd_q <= command;
               arg_q <= {regIn7, regIn6, regIn5, regIn4, regIn3, regIn2, regIn1, regIn0};
               error <= 1'b0;
            end
            EXEC: state <= do_read ? RD_WAIT : ACK_WAIT;
            RD_WAIT: if (rdValid) state <= ACK_WAIT;
            default: begin
               if (timeout && !ack_cmd) error <= 1'b1;
               if (ack_cmd || timeout) state <= IDLE;
            end
         endcase
      end
endmodule

// File: tb/tb_cmd_handler.sv
// tb_cmd_handler: directed and randomized command sequences checked against a behavioural model of the host protocol.
module tb_cmd_handler;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [7:0]  command = 8'h00;
   logic        commandStrobe = 1'b0;
   logic [63:0] args_drv = '0;
   logic [7:0]  regIn0, regIn1, regIn2, regIn3, regIn4, regIn5, regIn6, regIn7;
   logic [7:0]  regOut0, regOut1, regOut2, regOut3, regOut4, regOut5, regOut6, regOut7;
   logic [7:0]  status;
   logic        capArmed = 1'b0, capTriggered = 1'b0, capDone = 1'b0;
   logic        startPulse, abortPulse, softResetPulse, cfgValid, rdReq;
   logic        rdValid = 1'b0;
   logic [31:0] cfgTotal, cfgPreTrig;
   logic [31:0] rdData = '0, traceSize = '0, trigSample = '0;

   int checks = 0, errors = 0;
   int n_start = 0, n_abort = 0, n_srst = 0, n_cfgv = 0, n_rd = 0, n_ack = 0;
   logic [63:0] exp_out = '0;
   logic [31:0] exp_total = '0, exp_pre = '0;
   logic        exp_err = 1'b0;
   logic [7:0]  codes [10];
   logic [7:0]  ign_codes [5];

   assign {regIn7, regIn6, regIn5, regIn4, regIn3, regIn2, regIn1, regIn0} = args_drv;

   cmd_handler #(.SAMPLE_W(32), .ACK_TIMEOUT_CLKS(16)) dut (
      .clk(clk), .resetn(resetn), .command(command), .commandStrobe(commandStrobe),
      .regIn0(regIn0), .regIn1(regIn1), .regIn2(regIn2), .regIn3(regIn3),
      .regIn4(regIn4), .regIn5(regIn5), .regIn6(regIn6), .regIn7(regIn7),
      .regOut0(regOut0), .regOut1(regOut1), .regOut2(regOut2), .regOut3(regOut3),
      .regOut4(regOut4), .regOut5(regOut5), .regOut6(regOut6), .regOut7(regOut7),
      .status(status), .capArmed(capArmed), .capTriggered(capTriggered), .capDone(capDone),
      .startPulse(startPulse), .abortPulse(abortPulse), .softResetPulse(softResetPulse),
      .cfgTotal(cfgTotal), .cfgPreTrig(cfgPreTrig), .cfgValid(cfgValid),
      .rdReq(rdReq), .rdData(rdData), .rdValid(rdValid), .traceSize(traceSize), .trigSample(trigSample)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (startPulse) n_start++;
      if (abortPulse) n_abort++;
      if (softResetPulse) n_srst++;
      if (cfgValid) n_cfgv++;
      if (rdReq) n_rd++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] reg_out();
      return {regOut7, regOut6, regOut5, regOut4, regOut3, regOut2, regOut1, regOut0};
   endfunction

   // One complete host transaction: strobe, optional trace read after d wait cycles, ignored strobe, ACK.
   task automatic run_cmd(input logic [7:0] code, input logic [63:0] args, input int d,
                          input logic [7:0] ign, input logic [31:0] rdv);
      logic [31:0] tot, pre;
      logic legal, rd, cfg_ok;
      int b_start, b_abort, b_srst, b_cfgv, b_rd;
      tot    = args[31:0];
      pre    = args[63:32];
      legal  = code inside {8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h09};
      cfg_ok = pre > 0 && pre < tot;
      rd     = code == 8'h05 && capDone;
      exp_err = !legal || (code == 8'h01 && capArmed) || (code == 8'h04 && !cfg_ok) || (code == 8'h05 && !capDone);
      if (code == 8'h04 && cfg_ok) begin
         exp_total = tot;
         exp_pre   = pre;
      end
      if (code == 8'h06) exp_out = {32'd0, traceSize};
      if (code == 8'h07 || code == 8'h10) exp_out = {32'd0, trigSample};
      if (rd) exp_out = {32'd0, rdv};
      b_start = n_start; b_abort = n_abort; b_srst = n_srst; b_cfgv = n_cfgv; b_rd = n_rd;
      @(negedge clk);
      command = code; args_drv = args; commandStrobe = 1'b1;
      @(negedge clk);
      command = 8'($urandom); commandStrobe = 1'($urandom_range(0, 1)); args_drv = {$urandom, $urandom};
      #1;
      chk("busy_exec", status[5], 1);
      chk("err_clr_exec", status[4], 0);
      if (rd) begin
         @(negedge clk);
         commandStrobe = 1'b0;
         repeat (d) @(negedge clk);
         rdData = rdv; rdValid = 1'b1;
         @(negedge clk);
         rdValid = 1'b0;
      end else @(negedge clk);
      command = ign; commandStrobe = 1'b1;
      @(negedge clk);
      commandStrobe = 1'b0;
      #1;
      chk("ack_set", status[3], 1);
      chk("busy_ack", status[5], 1);
      chk("err", status[4], exp_err);
      chk("reg_out", reg_out(), exp_out);
      chk("cfg_total", cfgTotal, exp_total);
      chk("cfg_pre", cfgPreTrig, exp_pre);
      chk("n_start", n_start - b_start, (code == 8'h01 && !capArmed) ? 1 : 0);
      chk("n_abort", n_abort - b_abort, code == 8'h02 ? 1 : 0);
      chk("n_srst", n_srst - b_srst, code == 8'h09 ? 1 : 0);
      chk("n_cfgv", n_cfgv - b_cfgv, (code == 8'h04 && cfg_ok) ? 1 : 0);
      chk("n_rdreq", n_rd - b_rd, rd ? 2 + d : 0);
      @(negedge clk);
      command = 8'h08; commandStrobe = 1'b1;
      @(negedge clk);
      commandStrobe = 1'b0;
      #1;
      chk("ack_clr", status[3], 0);
      chk("busy_idle", status[5], 0);
      chk("err_sticky", status[4], exp_err);
   endtask

   initial begin
      codes = '{8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07, 8'h10, 8'h09, 8'h3C, 8'hFF};
      ign_codes = '{8'h01, 8'h02, 8'h04, 8'h09, 8'h3C};
      repeat (3) @(negedge clk);
      #1;
      chk("rst_status", status, 8'h00);
      chk("rst_regout", reg_out(), 64'd0);
      chk("rst_cfg", {cfgTotal, cfgPreTrig}, 64'd0);
      chk("rst_pulses", {startPulse, abortPulse, softResetPulse, cfgValid, rdReq}, 0);
      resetn = 1'b1;
      capArmed = 1'b1; capTriggered = 1'b0; capDone = 1'b1;
      #1;
      chk("mirror", status[2:0], 3'b101);
      capArmed = 1'b0; capDone = 1'b0;
      @(negedge clk); command = 8'h00; commandStrobe = 1'b1;
      @(negedge clk); command = 8'h08;
      @(negedge clk); commandStrobe = 1'b0;
      #1;
      chk("nop_ack_ignored", status[5:3], 3'b000);
      run_cmd(8'h04, {32'd20, 32'd110}, 0, 8'h02, 0);
      run_cmd(8'h04, {32'd120, 32'd110}, 0, 8'h01, 0);
      run_cmd(8'h04, {32'd110, 32'd110}, 0, 8'h01, 0);
      run_cmd(8'h04, {32'd0, 32'd110}, 0, 8'h01, 0);
      run_cmd(8'h04, {32'd109, 32'd110}, 0, 8'h01, 0);
      capDone = 1'b1;
      run_cmd(8'h05, 64'd0, 1, 8'h01, 32'hA5);
      capDone = 1'b0;
      run_cmd(8'h05, 64'd0, 1, 8'h01, 32'h5A);
      capArmed = 1'b0;
      run_cmd(8'h01, 64'd0, 0, 8'h02, 0);
      capArmed = 1'b1;
      run_cmd(8'h01, 64'd0, 0, 8'h02, 0);
      run_cmd(8'h3C, 64'd0, 0, 8'h01, 0);
      traceSize = 32'h1234_5678;
      run_cmd(8'h06, 64'd0, 0, 8'h01, 0);
      trigSample = 32'hCAFE_0001;
      run_cmd(8'h07, 64'd0, 0, 8'h01, 0);
      trigSample = 32'hBEEF_0002;
      run_cmd(8'h10, 64'd0, 0, 8'h01, 0);
      run_cmd(8'h02, 64'd0, 0, 8'h09, 0);
      run_cmd(8'h09, 64'd0, 0, 8'h02, 0);
      for (int i = 0; i < 60; i++) begin
         logic [7:0] code;
         logic [31:0] t, p;
         code = codes[$urandom_range(0, 9)];
         t = $urandom_range(2, 5000);
         case ($urandom_range(0, 3))
            0: p = $urandom_range(1, t - 1);
            1: p = t;
            2: p = 0;
            default: p = $urandom;
         endcase
         capArmed = 1'($urandom_range(0, 1));
         capDone = 1'($urandom_range(0, 1));
         capTriggered = 1'($urandom_range(0, 1));
         traceSize = $urandom;
         trigSample = $urandom;
         #1;
         chk("mirror_rand", status[2:0], {capDone, capTriggered, capArmed});
         run_cmd(code, {p, t}, $urandom_range(0, 3), ign_codes[$urandom_range(0, 4)], $urandom);
      end
      capDone = 1'b1;
      @(negedge clk); command = 8'h05; commandStrobe = 1'b1;
      @(negedge clk); commandStrobe = 1'b0;
      @(negedge clk);
      #1;
      chk("rdreq_wait", rdReq, 1);
      resetn = 1'b0;
      #1;
      exp_out = '0; exp_total = '0; exp_pre = '0; exp_err = 1'b0;
      chk("rst_mid_rdreq", rdReq, 0);
      chk("rst_mid_status", status[5:3], 3'b000);
      chk("rst_mid_regout", reg_out(), exp_out);
      chk("rst_mid_cfg", {cfgTotal, cfgPreTrig}, {exp_total, exp_pre});
      begin
         int b_p;
         b_p = n_start + n_abort + n_srst + n_cfgv;
         @(negedge clk); resetn = 1'b1;
         repeat (3) @(negedge clk);
         #1;
         chk("rst_no_pulses", n_start + n_abort + n_srst + n_cfgv - b_p, 0);
         chk("rst_idle", {status[5], rdReq}, 2'b00);
      end
      capArmed = 1'b0;
      @(negedge clk); command = 8'h02; commandStrobe = 1'b1;
      @(negedge clk); commandStrobe = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (status[3]) n_ack++;
      end
`ifdef CMD_HANDLER_ACK_TIMEOUT_EN
      chk("timeout_cycles", n_ack, 16);
      chk("timeout_state", status[5:3], 3'b010);
`else
      chk("no_timeout", n_ack, 40);
      chk("no_timeout_state", status[5:3], 3'b101);
      @(negedge clk); command = 8'h08; commandStrobe = 1'b1;
      @(negedge clk); commandStrobe = 1'b0;
      #1;
      chk("late_ack", status[5:3], 3'b000);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
